// File: rtl/cpld_uart_pkg.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | cpld_uart_pkg: state encodings, bit timing constants, oversample divider |
// | Rev 1.0                                                                  |
// +--------------------------------------------------------------------------+
package cpld_uart_pkg;

  localparam int unsigned TICKS_PER_BIT = 16;
  localparam int unsigned RX_MID_TICK   = 8;
  localparam int unsigned DATA_BITS     = 8;

  typedef enum logic [1:0] {
    TX_IDLE  = 2'd0,
    TX_START = 2'd1,
    TX_DATA  = 2'd2,
    TX_STOP  = 2'd3
  } tx_state_t;

  typedef enum logic [2:0] {
    RX_IDLE   = 3'd0,
    RX_START  = 3'd1,
    RX_DATA   = 3'd2,
    RX_STOP   = 3'd3,
    RX_WAITHI = 3'd4
  } rx_state_t;

  // Clamp to 1 so a slow clock still produces a tick every cycle.
  function automatic int unsigned calc_ovs_div(input int unsigned clk_freq,
                                               input int unsigned baud);
    int unsigned div;
    div = clk_freq / (baud * TICKS_PER_BIT);
    return (div < 1) ? 1 : div;
  endfunction

endpackage
`default_nettype wire

// File: rtl/cpld_uart_rx_fifo.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | cpld_uart_rx_fifo: synchronous receive FIFO, head visible combinationally |
// | Rev 1.0                                                                  |
// +--------------------------------------------------------------------------+
module cpld_uart_rx_fifo #(
  parameter int unsigned DEPTH = 4,
  parameter int unsigned WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             i_push,
  input  logic [WIDTH-1:0] i_data,
  input  logic             i_pop,
  output logic [WIDTH-1:0] o_head,
  output logic             o_empty,
  output logic             o_full
);

  localparam int unsigned PTR_W = $clog2(DEPTH);

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [PTR_W-1:0] r_wr_ptr;
  logic [PTR_W-1:0] r_rd_ptr;
  logic [PTR_W:0]   r_count;
  logic             w_do_push;
  logic             w_do_pop;

  assign o_empty   = (r_count == '0);
  assign o_full    = (r_count == (PTR_W+1)'(DEPTH));
  assign o_head    = r_mem[r_rd_ptr];
  assign w_do_pop  = i_pop && !o_empty;
  assign w_do_push = i_push && (!o_full || w_do_pop);

  always_ff @(posedge clk) begin
    if (w_do_push) begin
      r_mem[r_wr_ptr] <= i_data;
    end
  end

  // Pointers are exactly log2(DEPTH) bits so they wrap for free.
  always_ff @(posedge clk) begin
    if (!rst) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_do_push) r_wr_ptr <= r_wr_ptr + PTR_W'(1);
      if (w_do_pop)  r_rd_ptr <= r_rd_ptr + PTR_W'(1);
      case ({w_do_push, w_do_pop})
        2'b10:   r_count <= r_count + (PTR_W+1)'(1);
        2'b01:   r_count <= r_count - (PTR_W+1)'(1);
        default: r_count <= r_count;
      endcase
    end
  end

endmodule
`default_nettype wire

// File: rtl/cpld_uart_responder.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | cpld_uart_responder: CPLD-style rdn/wrn UART handshake bridged to txd/rxd |
// | Rev 1.0                                                                  |
// +--------------------------------------------------------------------------+
module cpld_uart_responder
  import cpld_uart_pkg::*;
#(
  parameter int unsigned CLK_FREQ = 11059200,
  parameter int unsigned BAUD     = 115200,
  parameter int unsigned OVS_DIV  = calc_ovs_div(CLK_FREQ, BAUD),
  parameter int unsigned RX_DEPTH = 4
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       uart_rdn,
  input  logic       uart_wrn,
  input  logic [7:0] data_i,
  output logic [7:0] data_o,
  output logic       data_oe,
  output logic       uart_dataready,
  output logic       uart_tbre,
  output logic       uart_tsre,
  output logic       txd,
  input  logic       rxd
);

  localparam int unsigned OVS_W     = (OVS_DIV > 1) ? $clog2(OVS_DIV) : 1;
  localparam logic [3:0]  C_LAST_TK = 4'(TICKS_PER_BIT - 1);
  localparam logic [3:0]  C_MID_TK  = 4'(RX_MID_TICK - 1);
  localparam logic [2:0]  C_LAST_BT = 3'(DATA_BITS - 1);

  logic [OVS_W-1:0] r_ovs_cnt;
  logic             w_tick;
  logic             r_rdn_q;
  logic             r_wrn_q;
  logic             w_rd_rise;
  logic             w_wr_rise;
  logic             w_wr_accept;
  logic             r_dataready;

  tx_state_t        r_tx_state;
  logic [7:0]       r_thr;
  logic             r_thr_full;
  logic [7:0]       r_tx_shift;
  logic [3:0]       r_tx_tick;
  logic [2:0]       r_tx_bit;
  logic             r_txd;
  logic             r_tsre;

  rx_state_t        r_rx_state;
  logic             r_rxd_s1;
  logic             r_rxd_s2;
  logic             r_rxd_s3;
  logic             w_rx_fall;
  logic [7:0]       r_rx_shift;
  logic [3:0]       r_rx_tick;
  logic [2:0]       r_rx_bit;
  logic             w_rx_push;

  logic [7:0]       w_fifo_head;
  logic             w_fifo_empty;
  logic             w_fifo_full;

  assign w_tick      = (r_ovs_cnt == OVS_W'(OVS_DIV - 1));
  assign w_rd_rise   = !r_rdn_q && uart_rdn;
  assign w_wr_rise   = !r_wrn_q && uart_wrn;
  assign w_wr_accept = w_wr_rise && !r_thr_full;
  assign w_rx_fall   = r_rxd_s3 && !r_rxd_s2;
  assign w_rx_push   = (r_rx_state == RX_STOP) && w_tick && (r_rx_tick == C_LAST_TK)
                       && r_rxd_s2 && !w_fifo_full;

  assign data_oe        = ~uart_rdn;
  assign data_o         = w_fifo_empty ? 8'h00 : w_fifo_head;
  assign uart_dataready = r_dataready;
  assign uart_tbre      = ~r_thr_full;
  assign uart_tsre      = r_tsre;
  assign txd            = r_txd;

  // Strobe history resets high so releasing rst never looks like a rising edge.
  always_ff @(posedge clk) begin
    if (!rst) begin
      r_ovs_cnt   <= '0;
      r_rdn_q     <= 1'b1;
      r_wrn_q     <= 1'b1;
      r_dataready <= 1'b0;
    end else begin
      r_ovs_cnt   <= w_tick ? '0 : r_ovs_cnt + OVS_W'(1);
      r_rdn_q     <= uart_rdn;
      r_wrn_q     <= uart_wrn;
      r_dataready <= ~w_fifo_empty;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      r_tx_state <= TX_IDLE;
      r_thr      <= 8'h00;
      r_thr_full <= 1'b0;
      r_tx_shift <= 8'h00;
      r_tx_tick  <= 4'd0;
      r_tx_bit   <= 3'd0;
      r_txd      <= 1'b1;
      r_tsre     <= 1'b1;
    end else begin
      if (w_wr_accept) begin
        r_thr      <= data_i;
        r_thr_full <= 1'b1;
        r_tsre     <= 1'b0;
      end
      case (r_tx_state)
        TX_IDLE: begin
          if (r_thr_full && w_tick) begin
            r_tx_shift <= r_thr;
            r_thr_full <= 1'b0;
            r_txd      <= 1'b0;
            r_tx_tick  <= 4'd0;
            r_tx_state <= TX_START;
          end
        end
        default: begin
          if (w_tick) begin
            if (r_tx_tick != C_LAST_TK) begin
              r_tx_tick <= r_tx_tick + 4'd1;
            end else begin
              r_tx_tick <= 4'd0;
              case (r_tx_state)
                TX_START: begin
                  r_txd      <= r_tx_shift[0];
                  r_tx_bit   <= 3'd0;
                  r_tx_state <= TX_DATA;
                end
                TX_DATA: begin
                  if (r_tx_bit == C_LAST_BT) begin
                    r_txd      <= 1'b1;
                    r_tx_state <= TX_STOP;
                  end else begin
                    r_tx_shift <= r_tx_shift >> 1;
                    r_txd      <= r_tx_shift[1];
                    r_tx_bit   <= r_tx_bit + 3'd1;
                  end
                end
                TX_STOP: begin
                  // A pending byte chains straight into the next start bit.
                  if (r_thr_full) begin
                    r_tx_shift <= r_thr;
                    r_thr_full <= 1'b0;
                    r_txd      <= 1'b0;
                    r_tx_state <= TX_START;
                  end else begin
                    r_tx_state <= TX_IDLE;
                    if (!w_wr_accept) r_tsre <= 1'b1;
                  end
                end
                default: r_tx_state <= TX_IDLE;
              endcase
            end
          end
        end
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      r_rxd_s1   <= 1'b1;
      r_rxd_s2   <= 1'b1;
      r_rxd_s3   <= 1'b1;
      r_rx_state <= RX_IDLE;
      r_rx_shift <= 8'h00;
      r_rx_tick  <= 4'd0;
      r_rx_bit   <= 3'd0;
    end else begin
      r_rxd_s1 <= rxd;
      r_rxd_s2 <= r_rxd_s1;
      r_rxd_s3 <= r_rxd_s2;
      case (r_rx_state)
        RX_IDLE: begin
          if (w_rx_fall) begin
            r_rx_tick  <= 4'd0;
            r_rx_state <= RX_START;
          end
        end
        RX_START: begin
          if (w_tick) begin
            if (r_rx_tick == C_MID_TK) begin
              r_rx_tick <= 4'd0;
              r_rx_bit  <= 3'd0;
              r_rx_state <= r_rxd_s2 ? RX_IDLE : RX_DATA;
            end else begin
              r_rx_tick <= r_rx_tick + 4'd1;
            end
          end
        end
        RX_DATA: begin
          if (w_tick) begin
            if (r_rx_tick == C_LAST_TK) begin
              r_rx_tick  <= 4'd0;
              r_rx_shift <= {r_rxd_s2, r_rx_shift[7:1]};
              if (r_rx_bit == C_LAST_BT) r_rx_state <= RX_STOP;
              else                       r_rx_bit   <= r_rx_bit + 3'd1;
            end else begin
              r_rx_tick <= r_rx_tick + 4'd1;
            end
          end
        end
        RX_STOP: begin
          if (w_tick) begin
            if (r_rx_tick == C_LAST_TK) begin
              r_rx_tick  <= 4'd0;
              r_rx_state <= r_rxd_s2 ? RX_IDLE : RX_WAITHI;
            end else begin
              r_rx_tick <= r_rx_tick + 4'd1;
            end
          end
        end
        RX_WAITHI: begin
          if (r_rxd_s2) r_rx_state <= RX_IDLE;
        end
        default: r_rx_state <= RX_IDLE;
      endcase
    end
  end

  cpld_uart_rx_fifo #(
    .DEPTH (RX_DEPTH),
    .WIDTH (DATA_BITS)
  ) u_rx_fifo (
    .clk     (clk),
    .rst     (rst),
    .i_push  (w_rx_push),
    .i_data  (r_rx_shift),
    .i_pop   (w_rd_rise),
    .o_head  (w_fifo_head),
    .o_empty (w_fifo_empty),
    .o_full  (w_fifo_full)
  );

endmodule
`default_nettype wire

// File: tb/tb_cpld_uart_responder.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | tb_cpld_uart_responder: vector table plus TX/RX scoreboards              |
// | Rev 1.0                                                                  |
// +--------------------------------------------------------------------------+
module tb_cpld_uart_responder;

  localparam int BIT_CYC = 96;
  localparam int RXD     = 4;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       uart_rdn = 1'b1;
  logic       uart_wrn = 1'b1;
  logic       rxd = 1'b1;
  logic [7:0] data_i = 8'h00;
  logic [7:0] data_o;
  logic       data_oe;
  logic       uart_dataready;
  logic       uart_tbre;
  logic       uart_tsre;
  logic       txd;

  int checks   = 0;
  int failures = 0;

  logic [7:0] tx_q [$];
  logic [7:0] rx_q [$];
  logic       samp [0:1919];

  typedef struct {
    logic       rdn;
    logic       exp_oe;
    logic [7:0] exp_do;
    logic       exp_dr;
    logic       exp_tbre;
    logic       exp_tsre;
    logic       exp_txd;
  } vec_t;
  vec_t vecs [5];

  cpld_uart_responder dut (
    .clk            (clk),
    .rst            (rst),
    .uart_rdn       (uart_rdn),
    .uart_wrn       (uart_wrn),
    .data_i         (data_i),
    .data_o         (data_o),
    .data_oe        (data_oe),
    .uart_dataready (uart_dataready),
    .uart_tbre      (uart_tbre),
    .uart_tsre      (uart_tsre),
    .txd            (txd),
    .rxd            (rxd)
  );

  always #5 clk = ~clk;

  initial begin
    #3000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic cyc(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic write_byte(input logic [7:0] b);
    @(negedge clk);
    data_i   = b;
    uart_wrn = 1'b0;
    cyc(2);
    uart_wrn = 1'b1;
  endtask

  task automatic capture_raw(input int n, output bit ok);
    int t;
    t  = 0;
    ok = 1'b0;
    while (txd !== 1'b0 && t < 3000) begin
      @(negedge clk);
      t++;
    end
    if (txd !== 1'b0) return;
    ok = 1'b1;
    samp[0] = txd;
    for (int i = 1; i < n; i++) begin
      @(negedge clk);
      samp[i] = txd;
    end
  endtask

  task automatic check_frame(input string name, input int base);
    logic [7:0] b;
    logic [7:0] exp;
    for (int k = 0; k < 8; k++) b[k] = samp[base + 48 + BIT_CYC * (k + 1)];
    check({name, "_start"}, samp[base + 48], 1'b0);
    check({name, "_stop"}, samp[base + 48 + 9 * BIT_CYC], 1'b1);
    check({name, "_expected"}, tx_q.size() != 0, 1'b1);
    if (tx_q.size() != 0) exp = tx_q.pop_front();
    else                  exp = 8'h00;
    check({name, "_byte"}, b, exp);
  endtask

  task automatic send_rx(input logic [7:0] b, input logic stop_bit);
    logic [9:0] fr;
    fr = {stop_bit, b, 1'b0};
    if (stop_bit && rx_q.size() < RXD) rx_q.push_back(b);
    for (int k = 0; k < 10; k++) begin
      rxd = fr[k];
      cyc(BIT_CYC);
    end
    rxd = 1'b1;
    cyc(16);
  endtask

  task automatic wait_dr(input string name);
    int t;
    t = 0;
    while (uart_dataready !== 1'b1 && t < 400) begin
      @(negedge clk);
      t++;
    end
    check(name, uart_dataready, 1'b1);
  endtask

  task automatic read_check(input string name);
    logic [7:0] exp;
    @(negedge clk);
    check({name, "_dr"}, uart_dataready, rx_q.size() != 0);
    uart_rdn = 1'b0;
    #1;
    check({name, "_oe"}, data_oe, 1'b1);
    if (rx_q.size() != 0) exp = rx_q.pop_front();
    else                  exp = 8'h00;
    check({name, "_data"}, data_o, exp);
    @(negedge clk);
    uart_rdn = 1'b1;
    @(negedge clk);
  endtask

  task automatic count_low(input string name, input int n);
    int lows;
    lows = 0;
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      if (txd !== 1'b1) lows++;
    end
    check(name, lows, 0);
  endtask

  initial begin
    bit         ok;
    int         bad;
    int         t;
    logic [9:0] a5_frame;

    vecs[0] = '{1'b1, 1'b0, 8'h00, 1'b0, 1'b1, 1'b1, 1'b1};
    vecs[1] = '{1'b0, 1'b1, 8'h00, 1'b0, 1'b1, 1'b1, 1'b1};
    vecs[2] = '{1'b0, 1'b1, 8'h00, 1'b0, 1'b1, 1'b1, 1'b1};
    vecs[3] = '{1'b1, 1'b0, 8'h00, 1'b0, 1'b1, 1'b1, 1'b1};
    vecs[4] = '{1'b1, 1'b0, 8'h00, 1'b0, 1'b1, 1'b1, 1'b1};

    rst = 1'b0;
    cyc(3);
    rst = 1'b1;

    // Idle bus: read strobes on an empty FIFO, including an ignored pop.
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      uart_rdn = vecs[i].rdn;
      #1;
      check($sformatf("vec%0d_oe", i),   data_oe,        vecs[i].exp_oe);
      check($sformatf("vec%0d_do", i),   data_o,         vecs[i].exp_do);
      check($sformatf("vec%0d_dr", i),   uart_dataready, vecs[i].exp_dr);
      check($sformatf("vec%0d_tbre", i), uart_tbre,      vecs[i].exp_tbre);
      check($sformatf("vec%0d_tsre", i), uart_tsre,      vecs[i].exp_tsre);
      check($sformatf("vec%0d_txd", i),  txd,            vecs[i].exp_txd);
    end
    count_low("idle_txd_quiet", 2000);

    // Single write of 0xA5 with bit-by-bit timing.
    write_byte(8'hA5);
    tx_q.push_back(8'hA5);
    #1;
    check("a5_tbre_before_edge", uart_tbre, 1'b1);
    @(negedge clk);
    check("a5_tbre_after_edge", uart_tbre, 1'b0);
    check("a5_tsre_after_edge", uart_tsre, 1'b0);
    capture_raw(10 * BIT_CYC, ok);
    check("a5_start_seen", ok, 1'b1);
    a5_frame = {1'b1, 8'hA5, 1'b0};
    for (int k = 0; k < 10; k++) begin
      bad = 0;
      for (int j = 1; j < BIT_CYC - 1; j++)
        if (samp[k * BIT_CYC + j] !== a5_frame[k]) bad++;
      check($sformatf("a5_bit%0d_steady", k), bad, 0);
    end
    check_frame("a5", 0);
    cyc(3);
    check("a5_tsre_done", uart_tsre, 1'b1);
    check("a5_tbre_done", uart_tbre, 1'b1);

    // Back-to-back: 0x32 chains with no gap, 0x33 hits a full THR.
    write_byte(8'h31);
    tx_q.push_back(8'h31);
    @(negedge clk);
    check("b2b_tbre_busy", uart_tbre, 1'b0);
    fork
      capture_raw(20 * BIT_CYC, ok);
      begin
        t = 0;
        while (uart_tbre !== 1'b1 && t < 200) begin
          @(negedge clk);
          t++;
        end
        check("b2b_tbre_reload", uart_tbre, 1'b1);
        check("b2b_tsre_shifting", uart_tsre, 1'b0);
        write_byte(8'h32);
        tx_q.push_back(8'h32);
        write_byte(8'h33);
      end
    join
    check("b2b_start_seen", ok, 1'b1);
    check_frame("b2b_f1", 0);
    check_frame("b2b_f2", 10 * BIT_CYC);
    count_low("b2b_no_third_frame", 1500);
    check("b2b_tx_queue_drained", tx_q.size(), 0);
    check("b2b_tsre_end", uart_tsre, 1'b1);

    // Receive 0x5A and read it back.
    send_rx(8'h5A, 1'b1);
    wait_dr("rx5a_dataready");
    read_check("rx5a_read");
    @(negedge clk);
    check("rx5a_dr_clear", uart_dataready, 1'b0);

    // Overrun and pointer wrap: six bytes into four entries, three times.
    for (int r = 0; r < 3; r++) begin
      for (int v = 1; v <= 6; v++) send_rx(8'(v), 1'b1);
      wait_dr($sformatf("ovr%0d_dataready", r));
      while (rx_q.size() != 0) read_check($sformatf("ovr%0d_read", r));
      cyc(2);
      check($sformatf("ovr%0d_dr_clear", r), uart_dataready, 1'b0);
    end
    read_check("empty_read");

    // Short glitch is a false start.
    @(negedge clk);
    rxd = 1'b0;
    cyc(18);
    rxd = 1'b1;
    cyc(300);
    check("glitch_no_push", uart_dataready, 1'b0);

    // Framing error discards, then the receiver recovers.
    send_rx(8'h77, 1'b0);
    cyc(200);
    check("ferr_no_push", uart_dataready, 1'b0);
    send_rx(8'h12, 1'b1);
    wait_dr("rx12_dataready");
    read_check("rx12_read");
    cyc(2);
    check("rx12_dr_clear", uart_dataready, 1'b0);

    // Reset mid-frame aborts transmission immediately.
    write_byte(8'h00);
    t = 0;
    while (txd !== 1'b0 && t < 200) begin
      @(negedge clk);
      t++;
    end
    cyc(200);
    check("rst_mid_busy", txd, 1'b0);
    rst = 1'b0;
    @(negedge clk);
    check("rst_mid_txd", txd, 1'b1);
    check("rst_mid_tbre", uart_tbre, 1'b1);
    check("rst_mid_tsre", uart_tsre, 1'b1);
    check("rst_mid_dr", uart_dataready, 1'b0);
    cyc(2);
    rst = 1'b1;
    count_low("rst_frame_aborted", 1200);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
`default_nettype wire
